// File: rtl/ar_pkg.sv
// Shared widths, speed codes and config selectors for the ARINC 429 receive scheduler.
package ar_pkg;
    localparam int AR_NCH_MAX = 4;
    localparam int AR_ADR_W   = 8;
    localparam int AR_DAT_W   = 23;

    typedef enum logic [1:0] {
        NVEL_12K5 = 2'd0,
        NVEL_50K  = 2'd1,
        NVEL_100K = 2'd2,
        NVEL_1M   = 2'd3
    } nvel_e;

    typedef enum logic [1:0] {
        CFG_FILT    = 2'd0,
        CFG_NVEL    = 2'd1,
        CFG_CLR_OVF = 2'd2,
        CFG_RSVD    = 2'd3
    } cfg_sel_e;

    typedef struct packed {
        logic [AR_ADR_W-1:0] adr;
        logic [AR_DAT_W-1:0] dat;
    } word_t;
endpackage

// File: rtl/ar_ce_sync.sv
// Two-flop synchroniser plus rising-edge detect for one receiver strobe; det is 2-3 clk after the rise.
// Flops reset high so a strobe already asserted at reset release never looks like a new word.
module ar_ce_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ce,
    output logic o_det
);
    logic r_s1, r_s2, r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_ce;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_det = r_s2 & ~r_prev;
endmodule

// File: rtl/ar_rx_sched.sv
// Per-channel label filter and one-deep pending slot, round-robin onto a valid/ready output register.
// Strobe to out_vld 4-5 clk; output fields are held while out_vld & !out_rdy, overruns flagged per channel.
module ar_rx_sched
    import ar_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          ch_ce_wr,
    input  logic [AR_ADR_W*NCH-1:0] ch_adr,
    input  logic [AR_DAT_W*NCH-1:0] ch_dat,
    output logic [2*NCH-1:0]        ch_nvel,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [1:0]              cfg_ch,
    input  logic [7:0]              cfg_lbl,
    input  logic [1:0]              cfg_val,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [1:0]              out_ch,
    output logic [AR_ADR_W-1:0]     out_adr,
    output logic [AR_DAT_W-1:0]     out_dat,
    output logic [NCH-1:0]          ovf
);
    logic [NCH-1:0]          w_det;
    logic [NCH-1:0]          w_cap;
    logic [NCH-1:0]          w_ovf_set;
    logic [NCH-1:0]          w_ovf_clr;
    logic [NCH-1:0][255:0]   r_filt;
    logic [NCH-1:0][1:0]     r_nvel;
    logic [NCH-1:0]          r_ovf;
    word_t                   r_pend [NCH];
    logic [NCH-1:0]          r_pend_v;
    logic [1:0]              r_rr_ptr;
    word_t                   r_out;
    logic [1:0]              r_out_ch;
    logic                    r_out_vld;
    logic                    w_free;
    logic                    w_gnt;
    logic                    w_take;
    logic [1:0]              w_win;
    logic                    w_cfg_ok;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            ar_ce_sync u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_ce  (ch_ce_wr[g]),
                .o_det (w_det[g])
            );
            // Label lookup is combinational so a dropped word never touches pending state.
            assign w_cap[g]     = w_det[g] & r_filt[g][ch_adr[g*AR_ADR_W +: AR_ADR_W]];
            assign w_ovf_set[g] = w_cap[g] & r_pend_v[g] & ~(w_take && (w_win == 2'(g)));
            assign w_ovf_clr[g] = w_cfg_ok && (cfg_sel == CFG_CLR_OVF) && (cfg_ch == 2'(g));
        end
    endgenerate

    assign w_free   = ~r_out_vld | out_rdy;
    assign w_cfg_ok = cfg_we && (int'(cfg_ch) < NCH);

    always_comb begin
        w_gnt = 1'b0;
        w_win = 2'd0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_gnt && r_pend_v[(int'(r_rr_ptr) + k) % NCH]) begin
                w_gnt = 1'b1;
                w_win = 2'((int'(r_rr_ptr) + k) % NCH);
            end
        end
    end

    assign w_take = w_gnt & w_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_ch  <= 2'd0;
            r_out     <= '0;
            r_rr_ptr  <= 2'd0;
            r_pend_v  <= '0;
            r_ovf     <= '0;
            r_filt    <= '1;
            for (int i = 0; i < NCH; i++) begin
                r_pend[i] <= '0;
                r_nvel[i] <= NVEL_1M;
            end
        end else begin
            if (w_free) begin
                r_out_vld <= w_gnt;
                if (w_gnt) begin
                    r_out    <= r_pend[w_win];
                    r_out_ch <= w_win;
                    r_rr_ptr <= 2'((int'(w_win) + 1) % NCH);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                // A capture on the granted channel refills the slot, so pend_v stays set.
                if (w_cap[i]) begin
                    r_pend[i].adr <= ch_adr[i*AR_ADR_W +: AR_ADR_W];
                    r_pend[i].dat <= ch_dat[i*AR_DAT_W +: AR_DAT_W];
                    r_pend_v[i]   <= 1'b1;
                end else if (w_take && (w_win == 2'(i))) begin
                    r_pend_v[i]   <= 1'b0;
                end
                r_ovf[i] <= (r_ovf[i] & ~w_ovf_clr[i]) | w_ovf_set[i];
                if (w_cfg_ok && (cfg_sel == CFG_NVEL) && (cfg_ch == 2'(i)))
                    r_nvel[i] <= cfg_val;
            end
            if (w_cfg_ok && (cfg_sel == CFG_FILT))
                r_filt[cfg_ch][cfg_lbl] <= cfg_val[0];
        end
    end

    // Gating with rst_n drops out_vld in the reset cycle itself, not one edge later.
    assign out_vld = r_out_vld & rst_n;
    assign out_ch  = r_out_ch;
    assign out_adr = r_out.adr;
    assign out_dat = r_out.dat;
    assign ovf     = r_ovf;
    assign ch_nvel = r_nvel;
endmodule
